// File: rtl/mux8_serial_ctrl.sv
// mux8_serial_ctrl: steps an external 8:1 mux through a captured byte, forwards and cross-checks the serial stream.
module mux8_serial_ctrl #(
  parameter int DIV = 4,
  parameter bit MSB_FIRST = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  input  logic       abort,
  output logic [7:0] ch,
  output logic [2:0] sel,
  input  logic       mux_out,
  output logic       ser_out,
  output logic       ser_valid,
  output logic [2:0] bit_idx,
  output logic       busy,
  output logic       done,
  output logic       err,
  input  logic       err_clr
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state;
  logic [7:0] div_cnt;
  logic tick, fin;
  logic [2:0] sel_nxt;
  assign tick = state == SHIFT && div_cnt == 8'(DIV - 1);
  assign fin = tick && bit_idx == 3'd7;
  assign sel_nxt = MSB_FIRST ? sel - 3'd1 : sel + 3'd1;
  assign ser_out = ser_valid & mux_out;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ch <= '0;
      sel <= '0;
      bit_idx <= '0;
      div_cnt <= '0;
      ser_valid <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
      in_ready <= 1'b0;
    end else begin
      // a mismatch outranks a simultaneous clear
      err <= (tick && mux_out != ch[sel]) || (err && !err_clr);
      done <= 1'b0;
      case (state)
        IDLE:
          if (in_valid && in_ready) begin
            state <= SHIFT;
            ch <= in_data;
            sel <= MSB_FIRST ? 3'd7 : 3'd0;
            bit_idx <= '0;
            div_cnt <= '0;
            in_ready <= 1'b0;
            ser_valid <= 1'b1;
            busy <= 1'b1;
          end else in_ready <= 1'b1;
        SHIFT:
          if (abort) begin
            state <= IDLE;
            sel <= '0;
            ser_valid <= 1'b0;
            busy <= 1'b0;
            in_ready <= 1'b1;
          end else if (fin) begin
            state <= DONE;
            div_cnt <= '0;
            ser_valid <= 1'b0;
            done <= 1'b1;
          end else if (tick) begin
            div_cnt <= '0;
            sel <= sel_nxt;
            bit_idx <= bit_idx + 3'd1;
          end else div_cnt <= div_cnt + 8'd1;
        default: begin
          state <= IDLE;
          busy <= 1'b0;
          in_ready <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mux8_serial_ctrl.sv
// tb_mux8_serial_ctrl: directed table and sequence checks of LSB-first and MSB-first serializers at DIV=2.
module tb_mux8_serial_ctrl;
  logic clk = 0, rst = 1, in_valid = 0, abort = 0, err_clr = 0, stuck = 0;
  logic [7:0] in_data = '0;
  logic rdy0, ser0, vld0, bsy0, dn0, err0, mux0;
  logic rdy1, ser1, vld1, bsy1, dn1, err1, mux1;
  logic [7:0] ch0, ch1;
  logic [2:0] sel0, sel1, bidx0, bidx1;
  int checks = 0, failures = 0, ndone;
  always #5 clk = ~clk;
  assign mux0 = stuck ? 1'b0 : ch0[sel0];
  assign mux1 = ch1[sel1];
  mux8_serial_ctrl #(.DIV(2), .MSB_FIRST(0)) dut0 (.clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rdy0), .abort(abort), .ch(ch0), .sel(sel0), .mux_out(mux0), .ser_out(ser0), .ser_valid(vld0),
    .bit_idx(bidx0), .busy(bsy0), .done(dn0), .err(err0), .err_clr(err_clr));
  mux8_serial_ctrl #(.DIV(2), .MSB_FIRST(1)) dut1 (.clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rdy1), .abort(abort), .ch(ch1), .sel(sel1), .mux_out(mux1), .ser_out(ser1), .ser_valid(vld1),
    .bit_idx(bidx1), .busy(bsy1), .done(dn1), .err(err1), .err_clr(err_clr));
  typedef struct {
    logic s0, s1;
    logic [2:0] sl0, sl1, bi;
    logic v, d, r, b;
  } vec_t;
  vec_t tbl[18];
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask
  task automatic chk_reset(input string nm);
    chk({nm, "_ch"}, int'(ch0), 0);
    chk({nm, "_sel"}, int'(sel0), 0);
    chk({nm, "_bidx"}, int'(bidx0), 0);
    chk({nm, "_vld"}, int'(vld0), 0);
    chk({nm, "_busy"}, int'(bsy0), 0);
    chk({nm, "_done"}, int'(dn0), 0);
    chk({nm, "_err"}, int'(err0), 0);
    chk({nm, "_rdy"}, int'(rdy0), 0);
    chk({nm, "_sel1"}, int'(sel1), 0);
  endtask
  initial begin
    tbl[0]  = '{0, 0, 0, 7, 0, 1, 0, 0, 1};
    tbl[1]  = '{0, 0, 0, 7, 0, 1, 0, 0, 1};
    tbl[2]  = '{1, 1, 1, 6, 1, 1, 0, 0, 1};
    tbl[3]  = '{1, 1, 1, 6, 1, 1, 0, 0, 1};
    tbl[4]  = '{0, 1, 2, 5, 2, 1, 0, 0, 1};
    tbl[5]  = '{0, 1, 2, 5, 2, 1, 0, 0, 1};
    tbl[6]  = '{1, 0, 3, 4, 3, 1, 0, 0, 1};
    tbl[7]  = '{1, 0, 3, 4, 3, 1, 0, 0, 1};
    tbl[8]  = '{0, 1, 4, 3, 4, 1, 0, 0, 1};
    tbl[9]  = '{0, 1, 4, 3, 4, 1, 0, 0, 1};
    tbl[10] = '{1, 0, 5, 2, 5, 1, 0, 0, 1};
    tbl[11] = '{1, 0, 5, 2, 5, 1, 0, 0, 1};
    tbl[12] = '{1, 1, 6, 1, 6, 1, 0, 0, 1};
    tbl[13] = '{1, 1, 6, 1, 6, 1, 0, 0, 1};
    tbl[14] = '{0, 0, 7, 0, 7, 1, 0, 0, 1};
    tbl[15] = '{0, 0, 7, 0, 7, 1, 0, 0, 1};
    tbl[16] = '{0, 0, 7, 0, 7, 0, 1, 0, 1};
    tbl[17] = '{0, 0, 7, 0, 7, 0, 0, 1, 0};
    step;
    step;
    chk_reset("rst");
    rst = 0;
    step;
    chk("rst_rdy_after", int'(rdy0), 1);
    // single byte through both selector directions
    in_valid = 1;
    in_data = 8'b01101010;
    step;
    in_valid = 0;
    for (int i = 0; i < 18; i++) begin
      chk($sformatf("t1_ser0[%0d]", i), int'(ser0), int'(tbl[i].s0));
      chk($sformatf("t1_ser1[%0d]", i), int'(ser1), int'(tbl[i].s1));
      chk($sformatf("t1_sel0[%0d]", i), int'(sel0), int'(tbl[i].sl0));
      chk($sformatf("t1_sel1[%0d]", i), int'(sel1), int'(tbl[i].sl1));
      chk($sformatf("t1_bidx[%0d]", i), int'(bidx0), int'(tbl[i].bi));
      chk($sformatf("t1_vld[%0d]", i), int'(vld0), int'(tbl[i].v));
      chk($sformatf("t1_done[%0d]", i), int'(dn0), int'(tbl[i].d));
      chk($sformatf("t1_rdy[%0d]", i), int'(rdy0), int'(tbl[i].r));
      chk($sformatf("t1_busy[%0d]", i), int'(bsy0), int'(tbl[i].b));
      step;
    end
    chk("t1_err0", int'(err0), 0);
    chk("t1_err1", int'(err1), 0);
    // back-to-back bytes with in_valid held high
    in_valid = 1;
    in_data = 8'hFF;
    step;
    in_data = 8'h00;
    ndone = 0;
    for (int c = 1; c <= 36; c++) begin
      if (c <= 16) begin
        chk($sformatf("t3_ser_ff[%0d]", c), int'(ser0), 1);
        chk($sformatf("t3_vld_ff[%0d]", c), int'(vld0), 1);
      end
      if (c >= 19 && c <= 34) begin
        chk($sformatf("t3_ser_00[%0d]", c), int'(ser0), 0);
        chk($sformatf("t3_vld_00[%0d]", c), int'(vld0), 1);
      end
      if (c == 17 || c == 35) chk($sformatf("t3_done[%0d]", c), int'(dn0), 1);
      if (c == 18) chk("t3_rdy_gap", int'(rdy0), 1);
      if (c == 19) begin
        chk("t3_ch2", int'(ch0), 8'h00);
        in_valid = 0;
      end
      ndone += int'(dn0);
      step;
    end
    chk("t3_ndone", ndone, 2);
    // abort on the 5th SHIFT cycle
    in_valid = 1;
    in_data = 8'hA5;
    step;
    in_valid = 0;
    repeat (4) step;
    chk("t4_vld_c5", int'(vld0), 1);
    abort = 1;
    step;
    abort = 0;
    chk("t4_rdy", int'(rdy0), 1);
    chk("t4_sel", int'(sel0), 0);
    chk("t4_sel1", int'(sel1), 0);
    chk("t4_vld", int'(vld0), 0);
    chk("t4_busy", int'(bsy0), 0);
    chk("t4_done", int'(dn0), 0);
    chk("t4_ch", int'(ch0), 8'hA5);
    ndone = 0;
    repeat (14) begin
      step;
      ndone += int'(dn0);
    end
    chk("t4_no_done", ndone, 0);
    in_valid = 1;
    in_data = 8'h3C;
    step;
    in_valid = 0;
    chk("t4_new_ch", int'(ch0), 8'h3C);
    chk("t4_new_vld", int'(vld0), 1);
    chk("t4_new_rdy", int'(rdy0), 0);
    for (int i = 0; i < 40 && !dn0; i++) step;
    chk("t4_new_done", int'(dn0), 1);
    chk("t4_new_err", int'(err0), 0);
    step;
    // stuck-at-0 mux, clear asserted alongside the first mismatch
    stuck = 1;
    in_valid = 1;
    in_data = 8'h01;
    step;
    in_valid = 0;
    chk("t5_err_c1", int'(err0), 0);
    step;
    chk("t5_err_c2", int'(err0), 0);
    err_clr = 1;
    step;
    err_clr = 0;
    chk("t5_err_set_wins", int'(err0), 1);
    for (int i = 0; i < 20 && !dn0; i++) step;
    chk("t5_done", int'(dn0), 1);
    chk("t5_err_at_done", int'(err0), 1);
    chk("t5_err1_ideal", int'(err1), 0);
    step;
    chk("t5_err_idle", int'(err0), 1);
    err_clr = 1;
    step;
    err_clr = 0;
    chk("t5_err_cleared", int'(err0), 0);
    stuck = 0;
    // reset mid-SHIFT
    in_valid = 1;
    in_data = 8'h5A;
    step;
    in_valid = 0;
    repeat (3) step;
    chk("t6_vld_pre", int'(vld0), 1);
    rst = 1;
    step;
    chk_reset("t6");
    rst = 0;
    step;
    chk("t6_rdy", int'(rdy0), 1);
    chk("t6_busy", int'(bsy0), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mux8_serial_ctrl.md
Name: mux8_serial_ctrl

Overview:
Sequencer that drives an external 8:1 mux (8-bit channel bus plus 3-bit selector) to serialize a parallel byte.
- Accepts one byte per valid/ready handshake.
- Presents the byte on the mux channel bus and steps the selector through all 8 positions, holding each for DIV clocks.
- Forwards the mux output as a serial bit stream.
- Cross-checks the mux output against the expected bit and flags a sticky error on mismatch.
- Sits between a byte producer and the mux/barrel-shifter datapath.

Parameters:
DIV, 4, clocks each selector value is held; legal range 1..255.
MSB_FIRST, 0, 0 = selector walks 0→7; 1 = selector walks 7→0.

Ports:
clk  in  1  system clock, rising-edge.
rst  in  1  synchronous, active-high reset.
in_valid  in  1  producer has a byte.
in_data  in  8  byte to serialize.
in_ready  out  1  controller can accept a byte.
abort  in  1  cancel current transfer.
ch  out  8  channel bus to mux; holds the captured byte.
sel  out  3  mux selector.
mux_out  in  1  mux output (combinational from ch/sel).
ser_out  out  1  serial bit; equals mux_out while ser_valid, else 0.
ser_valid  out  1  high during every SHIFT cycle.
bit_idx  out  3  number of bits already completed in the current byte (0..7).
busy  out  1  high in SHIFT and DONE.
done  out  1  one-cycle pulse on completion.
err  out  1  sticky mux-mismatch flag.
err_clr  in  1  clears err.

Behaviour:
- All outputs are registered except ser_out.
- Reset values: state=IDLE, ch=0, sel=0, bit_idx=0, ser_valid=0, busy=0, done=0, err=0, in_ready=0 during reset.
- In the first cycle after reset: IDLE with in_ready=1.
- States:
  - IDLE: in_ready=1. On in_valid&in_ready at an edge:
    - ch←in_data;
    - sel←(MSB_FIRST?7:0);
    - bit_idx←0;
    - div_cnt←0;
    - go to SHIFT.
  - SHIFT: in_ready=0, ser_valid=1, busy=1.
    - div_cnt increments each cycle.
    - When div_cnt==DIV-1: div_cnt←0 and advance sel (+1, or −1 if MSB_FIRST) and bit_idx.
    - After the 8th bit period completes: go to DONE. sel does not advance past the final position.
  - DONE: done=1 for exactly one cycle, busy=1, ser_valid=0, in_ready=0. Then go to IDLE.
- Timing: byte accepted at edge k → SHIFT occupies cycles k+1..k+8·DIV, DONE at cycle k+8·DIV+1, in_ready=1 at cycle k+8·DIV+2.
- in_valid while not in IDLE is ignored; the producer must hold it.
- abort in SHIFT → IDLE at the next edge:
  - no done pulse;
  - ch retains its value;
  - sel←0.
- abort on the final SHIFT cycle also wins (no DONE).
- abort in IDLE or DONE has no effect.
- Checker: on every SHIFT cycle where div_cnt==DIV-1, compare mux_out with ch[sel]; a mismatch sets err.
- err_clr clears err. If a mismatch and err_clr occur in the same cycle, set wins.
- err is retained across transfers and cleared only by err_clr or rst.
- rst asserted mid-transfer returns to the reset values at the next edge.

Test Plan:
- DIV=2, MSB_FIRST=0, in_data=8'b01101010, ideal mux model → ser_out over 16 SHIFT cycles = 0,0,1,1,0,0,1,1,0,0,1,1,1,1,0,0; done high at cycle 17 after accept; in_ready=1 at cycle 18; err=0.
- MSB_FIRST=1, same byte → sel sequence 7,7,6,6,…,0,0; ser_out = 0,0,1,1,1,1,0,0,1,1,0,0,1,1,0,0.
- Back-to-back: in_valid held high with bytes 8'hFF then 8'h00 → second accept on the first IDLE cycle after DONE; ser_out all 1s for 16 cycles, then all 0s; exactly two done pulses.
- abort asserted on the 5th SHIFT cycle → IDLE on the next cycle, no done, sel=0, in_ready=1; a new byte is then accepted normally.
- Fault injection: mux model with output stuck at 0, byte 8'h01 → err=1 after the first bit period and stays 1 through done. Then err_clr for one cycle → err=0.
- rst pulsed mid-SHIFT → all outputs at reset values on the next cycle; in_ready=1 one cycle after rst deasserts.
